// File: rtl/wb_arb2_if.sv
// Bus bundle for the two-master Wishbone arbiter: both master ports plus the
// single slave port toward the clock-domain bridge.
interface wb_arb2_if;
  logic [19:1] m0_adr_i;
  logic [19:1] m1_adr_i;
  logic [15:0] m0_dat_i;
  logic [15:0] m1_dat_i;
  logic [1:0]  m0_sel_i;
  logic [1:0]  m1_sel_i;
  logic        m0_tga_i;
  logic        m1_tga_i;
  logic        m0_we_i;
  logic        m1_we_i;
  logic        m0_stb_i;
  logic        m1_stb_i;
  logic        m0_cyc_i;
  logic        m1_cyc_i;
  logic [15:0] m0_dat_o;
  logic [15:0] m1_dat_o;
  logic        m0_ack_o;
  logic        m1_ack_o;

  logic [19:1] s_adr_o;
  logic [15:0] s_dat_o;
  logic [1:0]  s_sel_o;
  logic        s_tga_o;
  logic        s_we_o;
  logic        s_stb_o;
  logic        s_cyc_o;
  logic [15:0] s_dat_i;
  logic        s_ack_i;

  // Handshake: cyc frames a burst, cyc&stb is a pending beat, and ack high in
  // a cycle completes exactly one beat in that same cycle (no wait states implied).
  modport slave (
    input  m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    input  m0_tga_i, m1_tga_i, m0_we_i, m1_we_i, m0_stb_i, m1_stb_i,
    input  m0_cyc_i, m1_cyc_i, s_dat_i, s_ack_i,
    output m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
    output s_adr_o, s_dat_o, s_sel_o, s_tga_o, s_we_o, s_stb_o, s_cyc_o
  );

  modport master (
    output m0_adr_i, m1_adr_i, m0_dat_i, m1_dat_i, m0_sel_i, m1_sel_i,
    output m0_tga_i, m1_tga_i, m0_we_i, m1_we_i, m0_stb_i, m1_stb_i,
    output m0_cyc_i, m1_cyc_i, s_dat_i, s_ack_i,
    input  m0_dat_o, m1_dat_o, m0_ack_o, m1_ack_o,
    input  s_adr_o, s_dat_o, s_sel_o, s_tga_o, s_we_o, s_stb_o, s_cyc_o
  );
endinterface

// File: rtl/wb_arb2.sv
// Two-master round-robin Wishbone arbiter with a no-ack watchdog that
// terminates a stuck beat with an error ack of 16'hFFFF.
module wb_arb2 #(
    parameter int TIMEOUT = 256,
    parameter int TW      = 8
) (
    input  logic        wb_clk_i,
    input  logic        sys_rst_n,
    wb_arb2_if.slave    bus,
    output logic        gnt_o,
    output logic        busy_o,
    output logic        err_o,
    output logic [1:0]  state_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        ABORT = 2'd2
    } state_t;

    localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] WDOG_MAX  = {TW{1'b1}};

    state_t        state;
    logic          gnt;
    logic          last;
    logic [TW-1:0] wdog;

    logic req0;
    logic req1;
    logic g_cyc;
    logic g_stb;

    assign req0  = bus.m0_cyc_i & bus.m0_stb_i;
    assign req1  = bus.m1_cyc_i & bus.m1_stb_i;
    assign g_cyc = gnt ? bus.m1_cyc_i : bus.m0_cyc_i;
    assign g_stb = gnt ? bus.m1_stb_i : bus.m0_stb_i;

    always_ff @(posedge wb_clk_i or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= IDLE;
            gnt   <= 1'b0;
            last  <= 1'b1;
            wdog  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0 | req1) begin
                        gnt   <= (req0 & req1) ? ~last : req1;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (!g_cyc) begin
                        state <= IDLE;
                        last  <= gnt;
                        wdog  <= '0;
                    end else if (g_stb && !bus.s_ack_i) begin
                        // An ack in the final cycle still wins over the abort.
                        if (wdog == WDOG_LAST) begin
                            state <= ABORT;
                            wdog  <= '0;
                        end else if (wdog != WDOG_MAX) begin
                            wdog <= wdog + TW'(1);
                        end
                    end else begin
                        wdog <= '0;
                    end
                end
                ABORT: begin
                    wdog <= '0;
                    if (g_cyc) begin
                        state <= BUSY;
                    end else begin
                        state <= IDLE;
                        last  <= gnt;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address/data/select toward the slave always follow the grant; only
    // cyc/stb and the acks are gated by state.
    always_comb begin
        bus.s_adr_o  = gnt ? bus.m1_adr_i : bus.m0_adr_i;
        bus.s_dat_o  = gnt ? bus.m1_dat_i : bus.m0_dat_i;
        bus.s_sel_o  = gnt ? bus.m1_sel_i : bus.m0_sel_i;
        bus.s_tga_o  = gnt ? bus.m1_tga_i : bus.m0_tga_i;
        bus.s_we_o   = gnt ? bus.m1_we_i  : bus.m0_we_i;
        bus.s_cyc_o  = 1'b0;
        bus.s_stb_o  = 1'b0;
        bus.m0_ack_o = 1'b0;
        bus.m1_ack_o = 1'b0;
        bus.m0_dat_o = '0;
        bus.m1_dat_o = '0;
        case (state)
            BUSY: begin
                bus.s_cyc_o = g_cyc;
                bus.s_stb_o = g_cyc & g_stb;
                if (gnt) begin
                    bus.m1_ack_o = bus.s_ack_i;
                    bus.m1_dat_o = bus.s_dat_i;
                end else begin
                    bus.m0_ack_o = bus.s_ack_i;
                    bus.m0_dat_o = bus.s_dat_i;
                end
            end
            ABORT: begin
                if (gnt) begin
                    bus.m1_ack_o = 1'b1;
                    bus.m1_dat_o = 16'hFFFF;
                end else begin
                    bus.m0_ack_o = 1'b1;
                    bus.m0_dat_o = 16'hFFFF;
                end
            end
            default: ;
        endcase
    end

    assign gnt_o   = gnt;
    assign busy_o  = (state != IDLE);
    assign err_o   = (state == ABORT);
    assign state_o = state;

endmodule
